// File: rtl/nibble_serial_tx_if.sv
// nibble_serial_tx_if: write port and status/serial outputs of the nibble transmitter
//   i_wr_en, i_wr_data      : enqueue strobe and word (driven by master)
//   o_tx                    : serial line, idles high
//   o_busy, o_frame_done    : frame in progress / one-cycle completion pulse
//   o_full, o_empty, o_count: FIFO occupancy
//   o_overflow              : sticky rejected-write flag
interface nibble_serial_tx_if #(
  parameter int NBITS_DATA = 4,
  parameter int FIFO_DEPTH = 4
);
  logic                        i_wr_en;
  logic [NBITS_DATA-1:0]       i_wr_data;
  logic                        o_tx;
  logic                        o_busy;
  logic                        o_frame_done;
  logic                        o_full;
  logic                        o_empty;
  logic [$clog2(FIFO_DEPTH):0] o_count;
  logic                        o_overflow;
  modport slave (
    input  i_wr_en, i_wr_data,
    output o_tx, o_busy, o_frame_done, o_full, o_empty, o_count, o_overflow
  );
  modport master (
    output i_wr_en, i_wr_data,
    input  o_tx, o_busy, o_frame_done, o_full, o_empty, o_count, o_overflow
  );
endinterface

// File: rtl/nibble_serial_tx.sv
// nibble_serial_tx: FIFO-buffered framed serial transmitter (start, data LSB-first, parity, stop)
//   clk_2 : clock, all state changes on posedge
//   reset : asynchronous active-high reset
//   bus   : nibble_serial_tx_if.slave carrying write port, tx line and FIFO status
module nibble_serial_tx #(
  parameter int NBITS_DATA = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic               clk_2,
  input  logic               reset,
  nibble_serial_tx_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(NBITS_DATA + 1);
  localparam int KW = $clog2(BIT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                r_state, w_state_nx;
  logic [NBITS_DATA-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf, r_tx, r_done, r_par;
  logic [NBITS_DATA-1:0] r_shift, w_shift_nx;
  logic [BW-1:0]         r_bit, w_bit_nx;
  logic [KW-1:0]         r_cyc, w_cyc_nx;
  logic                  w_tx_nx, w_par_nx, w_done_nx, w_pop, w_push, w_bit_end;
  assign w_pop     = (r_state == IDLE) && (r_count != '0);
  // a pop frees a slot at the same edge, so a write while full is still taken
  assign w_push    = bus.i_wr_en && ((r_count != CW'(FIFO_DEPTH)) || w_pop);
  assign w_bit_end = r_cyc == KW'(BIT_CYCLES - 1);
  always_comb begin
    w_state_nx = r_state;
    w_tx_nx    = r_tx;
    w_shift_nx = r_shift;
    w_par_nx   = r_par;
    w_bit_nx   = r_bit;
    w_done_nx  = 1'b0;
    w_cyc_nx   = (r_state == IDLE || w_bit_end) ? '0 : r_cyc + KW'(1);
    case (r_state)
      IDLE: begin
        w_tx_nx = 1'b1;
        if (w_pop) begin
          w_state_nx = START;
          w_tx_nx    = 1'b0;
          w_shift_nx = r_mem[r_rptr];
          w_par_nx   = ^r_mem[r_rptr] ^ (PARITY_ODD != 0);
        end
      end
      START: if (w_bit_end) begin
        w_state_nx = DATA;
        w_tx_nx    = r_shift[0];
      end
      DATA: if (w_bit_end) begin
        if (r_bit == BW'(NBITS_DATA - 1)) begin
          w_state_nx = PARITY;
          w_tx_nx    = r_par;
          w_bit_nx   = '0;
        end else begin
          w_shift_nx = r_shift >> 1;
          w_tx_nx    = w_shift_nx[0];
          w_bit_nx   = r_bit + BW'(1);
        end
      end
      PARITY: if (w_bit_end) begin
        w_state_nx = STOP;
        w_tx_nx    = 1'b1;
      end
      STOP: if (w_bit_end) begin
        w_state_nx = IDLE;
        w_done_nx  = 1'b1;
      end
      default: begin
        w_state_nx = IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
      r_par   <= 1'b0;
      r_shift <= '0;
      r_bit   <= '0;
      r_cyc   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_tx    <= w_tx_nx;
      r_done  <= w_done_nx;
      r_par   <= w_par_nx;
      r_shift <= w_shift_nx;
      r_bit   <= w_bit_nx;
      r_cyc   <= w_cyc_nx;
      r_wptr  <= r_wptr + AW'(w_push);
      r_rptr  <= r_rptr + AW'(w_pop);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      r_ovf   <= r_ovf | (bus.i_wr_en & ~w_push);
    end
  end
  always_ff @(posedge clk_2) begin
    if (w_push) r_mem[r_wptr] <= bus.i_wr_data;
  end
  assign bus.o_tx         = r_tx;
  assign bus.o_busy       = r_state != IDLE;
  assign bus.o_frame_done = r_done;
  assign bus.o_full       = r_count == CW'(FIFO_DEPTH);
  assign bus.o_empty      = r_count == '0;
  assign bus.o_count      = r_count;
  assign bus.o_overflow   = r_ovf;
endmodule

// File: doc/nibble_serial_tx.md
# nibble_serial_tx

Buffered serial transmitter for 4-bit words, driven from the same switch/LED lab top as the 4x4 RAM and the parallel/serial register. Words written on a write strobe go into a small FIFO. An FSM drains the FIFO and sends each word on `tx` as a framed bitstream: start bit, data LSB-first, parity, stop. It sits downstream of the parallel/serial register, consuming the nibbles that register (or the RAM read port) produces.

## Interface
Parameters:
- `NBITS_DATA`, 4: data word width.
- `FIFO_DEPTH`, 4: number of FIFO entries; must be a power of 2, at least 2.
- `BIT_CYCLES`, 1: `clk_2` cycles per serial bit; must be at least 1.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity.

Ports:
- `clk_2`, in, 1: clock; all state changes on its posedge.
- `reset`, in, 1: asynchronous, active-high reset.
- `wr_en`, in, 1: write strobe, sampled at posedge.
- `wr_data`, in, `NBITS_DATA`: word to enqueue.
- `tx`, out, 1: serial line; idles high.
- `busy`, out, 1: high while a frame is in progress (state != IDLE).
- `frame_done`, out, 1: one-cycle pulse when a frame completes.
- `full`, out, 1: count == `FIFO_DEPTH`.
- `empty`, out, 1: count == 0.
- `count`, out, $clog2(`FIFO_DEPTH`)+1: number of FIFO entries.
- `overflow`, out, 1: sticky flag for a rejected write.

## Operation
Reset values (asynchronous, take effect immediately):
- `tx`=1, `busy`=0, `frame_done`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0.
- FSM in IDLE; FIFO pointers at 0; bit counter and cycle counter at 0.

FIFO:
- Circular buffer. Pointers wrap modulo `FIFO_DEPTH`.
- Pop occurs at the posedge where the FSM is in IDLE and `empty`=0.
- A write is accepted when `count` < `FIFO_DEPTH`, or when a pop occurs at the same edge. A write while full with a simultaneous pop is therefore accepted.
- Count update per edge:
  - write only: +1
  - pop only: -1
  - both: unchanged
- A rejected write sets `overflow`=1. It stays set until reset, and FIFO contents are unchanged.

FSM states and transitions:
- IDLE: `tx`=1. If `empty`=0, pop the head into the shift register, compute parity = XOR of the word ^ `PARITY_ODD`, and go to START.
- START: `tx`=0 for `BIT_CYCLES`, then go to DATA.
- DATA: `tx` = current shift-register bit 0. Shift right every `BIT_CYCLES`. After `NBITS_DATA` bits, go to PARITY.
- PARITY: `tx` = parity bit for `BIT_CYCLES`, then go to STOP.
- STOP: `tx`=1 for `BIT_CYCLES`, then go to IDLE and assert `frame_done` for the following cycle.

Output rules:
- `tx` is registered. It never glitches and changes only at posedge or on reset.
- IDLE is always occupied for at least one cycle between frames.
- `wr_data` changing mid-frame never affects the frame in flight.
- Reset during a frame aborts it: `tx` returns to 1 immediately, the FIFO is discarded, and no `frame_done` pulse is produced.

## Timing
All figures below assume `BIT_CYCLES`=1 and `NBITS_DATA`=4.

- Write at edge E into an empty FIFO, with the FSM idle:
  - after edge E: `count`=1, `empty`=0
  - after edge E+1: START, `tx`=0, `count`=0
  - after edges E+2 to E+5: data bits d0 to d3
  - after edge E+6: parity
  - after edge E+7: stop, `tx`=1
  - after edge E+8: IDLE, `frame_done`=1 for one cycle
  - edge E+9: next pop, if any
- Back-to-back frame period: `BIT_CYCLES`·(`NBITS_DATA`+3)+1 = 8 cycles.
- `full`, `empty`, `count` and `overflow` are registered. They update at the same edge as the write or pop that changes them.
- `busy` is high from the START edge through the end of STOP.

## Test plan
- Reset, write 4'b1011, `PARITY_ODD`=0 → `tx` sequence after successive edges: 0,1,1,0,1,1,1; then IDLE, `frame_done` pulses once, `count` 1→0.
- `PARITY_ODD`=1, write 4'b0000 → `tx`: 0,0,0,0,0,1,1. Write 4'b1111 → parity bit 1.
- Write 4 words in consecutive cycles (first pops one cycle after its write) → no overflow. Then write 6 more while the FSM is busy → `count` saturates at 4, `full`=1, `overflow`=1 sticky. Exactly 4+N words appear on `tx` in FIFO order, including the wrap-around of the pointers.
- FIFO full, `wr_en` held on the IDLE pop edge → write accepted, `count` stays 4, `overflow` unchanged.
- `BIT_CYCLES`=3 → each frame bit held exactly 3 cycles; frame period 22 cycles.
- Assert `reset` asynchronously mid-DATA with 2 words queued → `tx`=1 and `count`=0 before the next edge, no `frame_done`. After release with no writes, `tx` stays 1 indefinitely.
